// File: rtl/zx_mem_pager_if.sv
// Bus bundle between the Z80 CPU side and the memory pager.
// Latency: none; this is only a grouping of nets.
// Backpressure: none; the Z80 bus has no stall path through this bundle.
//
// Ports (master = CPU/bus side, slave = pager):
//   A, D, nM1, nMREQ, nIORQ, nRD, nWR : CPU bus, driven by the master
//   ram_addr, rom_addr, sel_rom, sel_trdos, ram_we, vid_page,
//   pager_q, locked                    : memory-array controls, driven by the pager
interface zx_mem_pager_if #(
    parameter int PAGE_BITS = 3
);
    logic [15:0]             A;
    logic [7:0]              D;
    logic                    nM1;
    logic                    nMREQ;
    logic                    nIORQ;
    logic                    nRD;
    logic                    nWR;

    logic [13+PAGE_BITS:0]   ram_addr;
    logic [14:0]             rom_addr;
    logic                    sel_rom;
    logic                    sel_trdos;
    logic                    ram_we;
    logic [2:0]              vid_page;
    logic [7:0]              pager_q;
    logic                    locked;

    modport master (
        output A, D, nM1, nMREQ, nIORQ, nRD, nWR,
        input  ram_addr, rom_addr, sel_rom, sel_trdos, ram_we, vid_page, pager_q, locked
    );

    modport slave (
        input  A, D, nM1, nMREQ, nIORQ, nRD, nWR,
        output ram_addr, rom_addr, sel_rom, sel_trdos, ram_we, vid_page, pager_q, locked
    );
endinterface

// File: rtl/zx_mem_pager.sv
// ZX-Spectrum 128k..1024k memory pager: port-7FFD register, TR-DOS shadow ROM, address map.
// Latency: address/select/we outputs are combinational; pager_q and TR-DOS state update on the CLOCK edge.
// Backpressure: none; the CPU bus is never stalled, each I/O bus cycle writes the register at most once.
//
// Ports:
//   CLOCK    : CPU clock, all state changes on its rising edge
//   RESET_N  : synchronous active-low reset, priority over every other update
//   bus      : zx_mem_pager_if.slave - CPU bus in, RAM/ROM address and selects out
module zx_mem_pager #(
    parameter int PAGE_BITS   = 3,
    parameter bit FULL_DECODE = 1'b0,
    parameter bit TRDOS_EN    = 1'b1
) (
    input  logic           CLOCK,
    input  logic           RESET_N,
    zx_mem_pager_if.slave  bus
);

    typedef enum logic {
        TR_OFF = 1'b0,
        TR_ON  = 1'b1
    } tr_state_t;

    tr_state_t              r_tr_state;
    tr_state_t              w_tr_next;

    logic [7:0]             r_pager;
    logic                   r_wr_seen;

    logic                   w_iow;
    logic                   w_port_hit;
    logic                   w_locked;
    logic                   w_port_wr;
    logic                   w_fetch;
    logic                   w_rom_sel;
    logic                   w_entry_now;
    logic                   w_exit_now;
    logic [PAGE_BITS-1:0]   w_sel_page;
    logic [PAGE_BITS-1:0]   w_page;

    // ------------------------------------------------------------------
    // Port 7FFD write qualification
    // ------------------------------------------------------------------
    assign w_iow = !bus.nIORQ && !bus.nWR && bus.nRD && bus.nM1;

    generate
        if (FULL_DECODE) begin : g_full_decode
            assign w_port_hit = (bus.A == 16'h7FFD);
        end else begin : g_part_decode
            assign w_port_hit = !bus.A[15] && !bus.A[1];
        end
    endgenerate

    // With 6 page bits D5 is a page-number bit, so it cannot double as the lock.
    generate
        if (PAGE_BITS < 6) begin : g_lock
            assign w_locked = r_pager[5];
        end else begin : g_nolock
            assign w_locked = 1'b0;
        end
    endgenerate

    // Only the first cycle of an I/O write counts, so wait states cannot
    // re-sample D and write twice.
    assign w_port_wr = w_iow && !r_wr_seen && w_port_hit && !w_locked;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_pager   <= 8'h00;
            r_wr_seen <= 1'b0;
        end else begin
            r_wr_seen <= w_iow;
            if (w_port_wr) begin
                r_pager <= bus.D;
            end
        end
    end

    // ------------------------------------------------------------------
    // Page number: low three bits, then Pentagon extension bits D6, D7, D5
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_page = '0;
        for (int i = 0; i < PAGE_BITS; i++) begin
            case (i)
                0, 1, 2: w_sel_page[i] = r_pager[i];
                3:       w_sel_page[i] = r_pager[6];
                4:       w_sel_page[i] = r_pager[7];
                default: w_sel_page[i] = r_pager[5];
            endcase
        end
    end

    always_comb begin
        w_page = '0;
        case (bus.A[15:14])
            2'b00:   w_page = '0;
            2'b01:   w_page = PAGE_BITS'(5);
            2'b10:   w_page = PAGE_BITS'(2);
            default: w_page = w_sel_page;
        endcase
    end

    assign w_rom_sel = r_pager[4];

    // ------------------------------------------------------------------
    // TR-DOS shadow ROM state
    // ------------------------------------------------------------------
    // Interrupt acknowledge has nMREQ high, so it never counts as a fetch.
    assign w_fetch     = !bus.nM1 && !bus.nMREQ;
    assign w_entry_now = TRDOS_EN && w_fetch && (bus.A[15:8] == 8'h3D) && w_rom_sel;
    assign w_exit_now  = w_fetch && (bus.A[15:14] != 2'b00);

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_tr_state <= TR_OFF;
        end else begin
            r_tr_state <= w_tr_next;
        end
    end

    // Dropping rom_sel while ON does not leave; only a fetch above 3FFF does.
    always_comb begin
        w_tr_next = r_tr_state;
        case (r_tr_state)
            TR_OFF:  if (w_entry_now) w_tr_next = TR_ON;
            TR_ON:   if (w_exit_now)  w_tr_next = TR_OFF;
            default: w_tr_next = TR_OFF;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ram_addr  = {w_page, bus.A[13:0]};
    assign bus.rom_addr  = {w_rom_sel, bus.A[13:0]};
    assign bus.sel_rom   = (bus.A[15:14] == 2'b00);
    // The entry fetch itself must already read the TR-DOS ROM.
    assign bus.sel_trdos = (r_tr_state == TR_ON) || w_entry_now;
    assign bus.ram_we    = !bus.nMREQ && !bus.nWR && (bus.A[15:14] != 2'b00);
    assign bus.vid_page  = r_pager[3] ? 3'd7 : 3'd5;
    assign bus.pager_q   = r_pager;
    assign bus.locked    = w_locked;

endmodule

// File: doc/zx_mem_pager.md
Name: zx_mem_pager

Overview:
- Parametrised ZX-Spectrum memory pager. Successor to the fixed 128k port-7FFD paging and TR-DOS latch in the DE0 top level.
- Decodes CPU bus writes to port 7FFD and tracks the TR-DOS ROM shadow state.
- Produces combinational RAM/ROM addresses, ROM selects, write enable and video bank for the memory arrays.
- Generalises RAM from 128k to 1024k (Pentagon-style extended page bits). Adds edge-qualified single port writes, a configurable port decode and a readback of the paging register.

Parameters:
- PAGE_BITS, 3, RAM page-number width. Legal values 3..6, giving 128k/256k/512k/1024k. The RAM address is 14+PAGE_BITS bits.
- FULL_DECODE, 0, port decode mode. 1: port matches only when A==16'h7FFD. 0: port matches when A[15]==0 and A[1]==0.
- TRDOS_EN, 1, TR-DOS shadow ROM enable. 0: sel_trdos is constant 0.

Ports:
- CLOCK  in  1  CPU clock; all state updates on its rising edge
- RESET_N  in  1  synchronous, active-low reset
- A  in  16  CPU address bus
- D  in  8  CPU data bus (write data)
- nM1  in  1  Z80 M1, active low
- nMREQ  in  1  memory request, active low
- nIORQ  in  1  I/O request, active low
- nRD  in  1  read strobe, active low
- nWR  in  1  write strobe, active low
- ram_addr  out  14+PAGE_BITS  RAM array address
- rom_addr  out  15  ROM address, {rom_sel, A[13:0]}
- sel_rom  out  1  A[15:14]==0; read data comes from a ROM
- sel_trdos  out  1  when sel_rom=1: 1 selects the TR-DOS ROM, 0 selects the main ROM
- ram_we  out  1  RAM write enable
- vid_page  out  3  screen bank: 5 or 7
- pager_q  out  8  current 7FFD register value
- locked  out  1  paging lock active

Behaviour:
- Reset (RESET_N=0 at a CLOCK edge) has priority over all other updates.
  - On reset: pager_q=0, trdos_q=0, wr_seen=0, so locked=0.
  - Combinational outputs then follow the bus: sel_trdos=0 unless an entry fetch is in progress; vid_page=5.
- I/O write event (iow) is 1 when nIORQ=0, nWR=0, nRD=1 and nM1=1.
  - wr_seen registers iow every cycle.
  - The port write fires only on the first cycle of iow (iow & !wr_seen), so each bus cycle writes exactly once regardless of wait length.
- Port write condition: port match (per FULL_DECODE) and locked=0. Action: pager_q <= D.
  - locked = pager_q[5] when PAGE_BITS<6. It is constant 0 when PAGE_BITS==6, because D5 is then a page bit.
  - Once locked, all 7FFD writes are ignored until reset.
- Page number is 3..6 bits, extended in this order:
  - bits [2:0] = pager_q[2:0]
  - bit 3 = pager_q[6]
  - bit 4 = pager_q[7]
  - bit 5 = pager_q[5]
  - The number is truncated to PAGE_BITS.
- rom_sel = pager_q[4]. Value 1 selects the 48k ROM.
- Address map (combinational):
  - 0000-3FFF: sel_rom=1, ram_addr = {page 0, A[13:0]}, ram_we=0.
  - 4000-7FFF: page 5.
  - 8000-BFFF: page 2.
  - C000-FFFF: selected page.
  - Page numbers 5 and 2 are zero-extended to PAGE_BITS.
- ram_we = !nMREQ & !nWR & (A[15:14]!=0). Combinational, no latency.
- vid_page = pager_q[3] ? 7 : 5.
- TR-DOS state machine has two states, OFF and ON. fetch = !nM1 & !nMREQ, which excludes interrupt acknowledge.
  - OFF->ON: fetch & A[15:8]==8'h3D & rom_sel=1 & TRDOS_EN.
  - ON->OFF: fetch & A[15:14]!=0.
  - Any other fetch, and any cycle without a fetch, keeps the current state.
  - sel_trdos = trdos_q | entry_now, where entry_now is the combinational OFF->ON condition. The first opcode fetched at 3Dxx therefore comes from the TR-DOS ROM with zero latency.
  - If rom_sel drops to 0 while ON, the state stays ON until exit.
  - Fetches in 0000-3FFF other than 3Dxx do not exit.
- Reset in the middle of a bus cycle clears wr_seen. If iow is still held after reset releases, it produces one port write in the first post-reset cycle.

Test Plan:
- Reset, then OUT (7FFD),8'h07 -> pager_q=07; read at C123 gives ram_addr={page 7,14'h0123}; vid_page=5. OUT 8'h0F -> vid_page=7.
- PAGE_BITS=5, OUT 7FFD,8'hC3 -> page=27; ram_addr at FFFF = 19'h6FFFF. PAGE_BITS=3, same write -> page=3, ram_addr=17'h0FFFF.
- Lock (PAGE_BITS=3): OUT 8'h20, then OUT 8'h07 -> pager_q stays 20, locked=1. RESET_N=0 for 1 cycle -> pager_q=0, locked=0. PAGE_BITS=6: OUT 8'h20 -> locked=0, page=32.
- Single-write check: iow held 4 cycles with D changing 11->22 on cycle 2 -> pager_q=11.
- FULL_DECODE=0: OUT to 7FF9 changes pager_q. FULL_DECODE=1: OUT to 7FF9 leaves pager_q unchanged; OUT to 7FFD changes it.
- TR-DOS, rom_sel=1:
  - M1 fetch at 3D2F -> sel_trdos=1 in the same cycle; trdos_q=1 next cycle.
  - Fetch at 0038 -> stays 1. Fetch at 5CC2 -> trdos_q=0.
  - With rom_sel=0, fetch at 3D2F -> sel_trdos=0.
  - A memory write at 3D00 never enters; ram_we=0 for that write.
